// File: rtl/siso_pkg.sv
// -----------------------------------------------------------------------------
// siso_pkg
// Shared definitions for the SISO half-iteration scheduler:
//   - sched_state_t : scheduler FSM states
//   - K_MIN_C / K_MAX_C : legal block-length window
//   - ADDR_W_C      : width of every step address / step counter
//   - legal_len()   : block-length legality check used on start accept
// -----------------------------------------------------------------------------
package siso_pkg;

  localparam int K_MIN_C  = 40;
  localparam int K_MAX_C  = 6144;
  localparam int ADDR_W_C = 13;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ALPHA  = 3'd2,
    ADRAIN = 3'd3,
    BETA   = 3'd4,
    LDRAIN = 3'd5,
    DONE   = 3'd6
  } sched_state_t;

  // True when the requested block length lies inside the supported window.
  function automatic logic legal_len(input logic [15:0] blklen);
    return (blklen >= 16'(K_MIN_C)) && (blklen <= 16'(K_MAX_C));
  endfunction

endpackage

// File: rtl/siso_step_cnt.sv
// -----------------------------------------------------------------------------
// siso_step_cnt
// Loadable up/down step counter used for the load, alpha and beta phases.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over en)
//   load_val  : value loaded on load
//   en        : step the counter one position
//   up        : 1 = count up, 0 = count down
//   bound     : terminal value
//   q         : current count
//   term      : q has reached bound
// -----------------------------------------------------------------------------
module siso_step_cnt
  import siso_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ADDR_W_C-1:0] load_val,
  input  logic                en,
  input  logic                up,
  input  logic [ADDR_W_C-1:0] bound,
  output logic [ADDR_W_C-1:0] q,
  output logic                term
);

  // Count register: load wins over stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= up ? (q + ADDR_W_C'(1)) : (q - ADDR_W_C'(1));
    end else begin
      q <= q;
    end
  end

  assign term = (q == bound);

endmodule

// File: rtl/siso_sched.sv
// -----------------------------------------------------------------------------
// siso_sched
// Block-level sequencer for one SISO decoder half-iteration. After a legal
// start it counts N = blklen + TAIL branch-metric writes, steps the alpha
// recursion 0..N-1, drains ALPHA_LAT cycles, steps beta N-1..0, and tags the
// LLR stage output (tail steps suppressed) before pulsing done.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, blklen : block request / length (sampled when start & ready)
//   ready         : scheduler idle and able to accept a block
//   valid_branch  : one branch-metric pair available
//   wr_en/wr_addr : branch storage write strobe / address
//   alpha_en/addr : alpha step enable / trellis step
//   beta_en/addr  : beta step enable / trellis step
//   llr_valid/idx : LLR qualifier / information-bit index
//   done          : one-cycle end-of-block pulse
//   err_len       : one-cycle pulse, start carried an illegal blklen
//   err_overrun   : sticky, valid_branch seen outside LOAD
//   cycles_last   : (SISO_SCHED_STATS_EN only) accept-to-done cycle count
// Optional feature macro: SISO_SCHED_STATS_EN
// All outputs are registered: the FSM computes next-cycle output values, so
// the state that "issues" a step runs one cycle ahead of the visible strobe.
// -----------------------------------------------------------------------------
module siso_sched
  import siso_pkg::*;
#(
  parameter int TAIL      = 4,
  parameter int ALPHA_LAT = 2,
  parameter int LLR_LAT   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         blklen,
  output logic                ready,
  input  logic                valid_branch,
  output logic                wr_en,
  output logic [ADDR_W_C-1:0] wr_addr,
  output logic                alpha_en,
  output logic [ADDR_W_C-1:0] alpha_addr,
  output logic                beta_en,
  output logic [ADDR_W_C-1:0] beta_addr,
  output logic                llr_valid,
  output logic [ADDR_W_C-1:0] llr_idx,
  output logic                done,
  output logic                err_len,
  output logic                err_overrun
`ifdef SISO_SCHED_STATS_EN
  ,
  output logic [31:0]         cycles_last
`endif
);

  // Elaboration-time checks on the configuration.
  if (K_MAX_C + TAIL > (1 << ADDR_W_C) - 1) begin : g_addr_w_chk
    $error("siso_sched: K_MAX + TAIL does not fit in ADDR_W bits");
  end
  if (LLR_LAT < 2 || ALPHA_LAT < 1) begin : g_lat_chk
    $error("siso_sched: LLR_LAT must be >= 2 and ALPHA_LAT >= 1");
  end

  sched_state_t        state_r, state_s;
  logic [ADDR_W_C-1:0] k_r, n_r, drain_r;
  logic                legal_s, accept_s, beat_s, drain_end_s;
  logic                ready_s, wr_en_s, alpha_en_s, beta_en_s, done_s, err_len_s;
  logic [ADDR_W_C-1:0] wr_addr_s, alpha_addr_s, beta_addr_s;
  logic [ADDR_W_C-1:0] load_q_s, alpha_q_s, beta_q_s;
  logic                load_term_s, alpha_term_s, beta_term_s;
  logic                alpha_load_s, beta_load_s;

  assign legal_s  = legal_len(blklen);
  assign accept_s = start & ready & (state_r == IDLE) & legal_s;
  assign beat_s   = valid_branch & (state_r == LOAD);
  // The last load beat issues alpha step 0 itself, so ALPHA resumes at step 1.
  assign alpha_load_s = beat_s & load_term_s;
  assign beta_load_s  = (state_r == ADRAIN) & drain_end_s;

  siso_step_cnt u_load_cnt (
    .clk(clk), .rst(rst), .load(accept_s), .load_val('0), .en(beat_s),
    .up(1'b1), .bound(n_r - ADDR_W_C'(1)), .q(load_q_s), .term(load_term_s)
  );

  siso_step_cnt u_alpha_cnt (
    .clk(clk), .rst(rst), .load(alpha_load_s), .load_val(ADDR_W_C'(1)),
    .en(state_r == ALPHA), .up(1'b1), .bound(n_r - ADDR_W_C'(1)),
    .q(alpha_q_s), .term(alpha_term_s)
  );

  siso_step_cnt u_beta_cnt (
    .clk(clk), .rst(rst), .load(beta_load_s), .load_val(n_r - ADDR_W_C'(1)),
    .en(state_r == BETA), .up(1'b0), .bound('0),
    .q(beta_q_s), .term(beta_term_s)
  );

  // Drain-phase end detection for the two fixed-length idle phases.
  always_comb begin
    drain_end_s = 1'b0;
    case (state_r)
      ADRAIN:  drain_end_s = (drain_r == ADDR_W_C'(ALPHA_LAT - 1));
      LDRAIN:  drain_end_s = (drain_r == ADDR_W_C'(LLR_LAT - 1));
      default: drain_end_s = 1'b0;
    endcase
  end

  // Next-state and next-cycle output values.
  always_comb begin
    state_s      = state_r;
    ready_s      = 1'b0;
    wr_en_s      = 1'b0;
    wr_addr_s    = '0;
    alpha_en_s   = 1'b0;
    alpha_addr_s = '0;
    beta_en_s    = 1'b0;
    beta_addr_s  = '0;
    done_s       = 1'b0;
    err_len_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = LOAD;
        end else begin
          ready_s   = 1'b1;
          err_len_s = start & ready & ~legal_s;
        end
      end
      LOAD: begin
        if (beat_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = load_q_s;
          if (load_term_s) begin
            alpha_en_s = 1'b1;
            state_s    = ALPHA;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      ALPHA: begin
        alpha_en_s   = 1'b1;
        alpha_addr_s = alpha_q_s;
        if (alpha_term_s) begin
          state_s = ADRAIN;
        end else begin
          state_s = ALPHA;
        end
      end
      ADRAIN: begin
        if (drain_end_s) begin
          state_s = BETA;
        end else begin
          state_s = ADRAIN;
        end
      end
      BETA: begin
        beta_en_s   = 1'b1;
        beta_addr_s = beta_q_s;
        if (beta_term_s) begin
          state_s = LDRAIN;
        end else begin
          state_s = BETA;
        end
      end
      LDRAIN: begin
        if (drain_end_s) begin
          state_s = DONE;
        end else begin
          state_s = LDRAIN;
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, block parameters and registered schedule outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= '0;
      n_r         <= '0;
      ready       <= 1'b1;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      alpha_en    <= 1'b0;
      alpha_addr  <= '0;
      beta_en     <= 1'b0;
      beta_addr   <= '0;
      done        <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_r    <= state_s;
      ready      <= ready_s;
      wr_en      <= wr_en_s;
      wr_addr    <= wr_addr_s;
      alpha_en   <= alpha_en_s;
      alpha_addr <= alpha_addr_s;
      beta_en    <= beta_en_s;
      beta_addr  <= beta_addr_s;
      done       <= done_s;
      err_len    <= err_len_s;
      if (accept_s) begin
        k_r         <= blklen[ADDR_W_C-1:0];
        n_r         <= blklen[ADDR_W_C-1:0] + ADDR_W_C'(TAIL);
        err_overrun <= 1'b0;
      end else begin
        err_overrun <= err_overrun | (valid_branch & (state_r != LOAD));
      end
    end
  end

  // Drain counter: restarts on every state change, runs in drain phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_r <= '0;
    end else if (state_s != state_r) begin
      drain_r <= '0;
    end else if (state_r == ADRAIN || state_r == LDRAIN) begin
      drain_r <= drain_r + ADDR_W_C'(1);
    end else begin
      drain_r <= '0;
    end
  end

  // LLR delay line of {beta_en, beta_addr}; tail steps (addr >= K) suppressed.
  logic [LLR_LAT-2:0]  dly_v_r;
  logic [ADDR_W_C-1:0] dly_idx_r [LLR_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_v_r   <= '0;
      llr_valid <= 1'b0;
      llr_idx   <= '0;
      for (int i = 0; i < LLR_LAT - 1; i++) begin
        dly_idx_r[i] <= '0;
      end
    end else begin
      dly_v_r[0]   <= beta_en;
      dly_idx_r[0] <= beta_addr;
      for (int i = 1; i < LLR_LAT - 1; i++) begin
        dly_v_r[i]   <= dly_v_r[i-1];
        dly_idx_r[i] <= dly_idx_r[i-1];
      end
      llr_valid <= dly_v_r[LLR_LAT-2] & (dly_idx_r[LLR_LAT-2] < k_r);
      llr_idx   <= dly_idx_r[LLR_LAT-2];
    end
  end

`ifdef SISO_SCHED_STATS_EN
  logic [31:0] cyc_r;

  // Accept-to-done cycle counter; both the accept and the done cycle count,
  // and done becomes visible one cycle after the DONE state, hence the +2.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r       <= 32'd0;
      cycles_last <= 32'd0;
    end else begin
      if (accept_s) begin
        cyc_r <= 32'd1;
      end else if (state_r != IDLE) begin
        cyc_r <= cyc_r + 32'd1;
      end else begin
        cyc_r <= cyc_r;
      end
      if (state_r == DONE) begin
        cycles_last <= cyc_r + 32'd2;
      end else begin
        cycles_last <= cycles_last;
      end
    end
  end
`else
  // Statistics counter not built in this configuration.
`endif

endmodule

// File: tb/tb_siso_sched.sv
// -----------------------------------------------------------------------------
// tb_siso_sched
// Self-checking bench for siso_sched. A cycle-indexed reference schedule is
// built from the block rules (write / alpha / beta / LLR / done cycles computed
// arithmetically from the last load beat) and compared every cycle.
// -----------------------------------------------------------------------------
module tb_siso_sched;
  import siso_pkg::*;

  localparam int TAIL = 4;
  localparam int ALAT = 2;
  localparam int LLAT = 3;
  localparam int MAXC = 65536;
  localparam int GUARD = 40000;

  logic                clk = 1'b0;
  logic                rst, start, valid_branch;
  logic [15:0]         blklen;
  logic                ready, wr_en, alpha_en, beta_en, llr_valid, done;
  logic                err_len, err_overrun;
  logic [ADDR_W_C-1:0] wr_addr, alpha_addr, beta_addr, llr_idx;
`ifdef SISO_SCHED_STATS_EN
  logic [31:0]         cycles_last;
`endif

  always #5 clk = ~clk;

  siso_sched #(.TAIL(TAIL), .ALPHA_LAT(ALAT), .LLR_LAT(LLAT)) dut (
    .clk(clk), .rst(rst), .start(start), .blklen(blklen), .ready(ready),
    .valid_branch(valid_branch), .wr_en(wr_en), .wr_addr(wr_addr),
    .alpha_en(alpha_en), .alpha_addr(alpha_addr), .beta_en(beta_en),
    .beta_addr(beta_addr), .llr_valid(llr_valid), .llr_idx(llr_idx),
    .done(done), .err_len(err_len), .err_overrun(err_overrun)
`ifdef SISO_SCHED_STATS_EN
    , .cycles_last(cycles_last)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cur = 0;

  // Expected per-cycle events.
  bit e_wr [MAXC];
  bit e_al [MAXC];
  bit e_be [MAXC];
  bit e_llr[MAXC];
  bit e_done[MAXC];
  bit e_elen[MAXC];
  int a_wr [MAXC];
  int a_al [MAXC];
  int a_be [MAXC];
  int a_llr[MAXC];
  int e_cyc[MAXC];

  // Model state.
  bit m_load = 1'b0;
  bit m_ovr = 1'b0;
  bit m_chk = 1'b0;
  int m_free_at = 0;
  int m_n = 0;
  int m_k = 0;
  int m_beats = 0;
  int m_acc = 0;
  int m_beta_vis = -100;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cur, act, exp);
    end
  endtask

  function automatic bit m_ready(input int c);
    return !m_load && (c >= m_free_at);
  endfunction

  task automatic check_outputs();
    logic [7:0] fa, fe;
    if (m_chk) begin
      fe = {m_ready(cur), e_wr[cur], e_al[cur], e_be[cur], e_llr[cur],
            e_done[cur], e_elen[cur], m_ovr};
      fa = {ready, wr_en, alpha_en, beta_en, llr_valid, done, err_len, err_overrun};
      chk("flags{rdy,wr,al,be,llr,done,elen,ovr}", {24'd0, fa}, {24'd0, fe});
      if (e_wr[cur])  chk("wr_addr",    32'(wr_addr),    a_wr[cur]);
      if (e_al[cur])  chk("alpha_addr", 32'(alpha_addr), a_al[cur]);
      if (e_be[cur])  chk("beta_addr",  32'(beta_addr),  a_be[cur]);
      if (e_llr[cur]) chk("llr_idx",    32'(llr_idx),    a_llr[cur]);
`ifdef SISO_SCHED_STATS_EN
      if (e_done[cur]) chk("cycles_last", cycles_last, e_cyc[cur]);
`endif
    end
  endtask

  // Reference: once the N-th beat lands at cycle L the whole remaining
  // schedule is fixed arithmetic on L, N and K.
  task automatic fill_schedule(input int L);
    int bc, st, done_c;
    for (int i = 0; i < m_n; i++) begin
      e_al[L + 1 + i] = 1'b1;
      a_al[L + 1 + i] = i;
      bc = L + 1 + m_n + ALAT + i;
      st = m_n - 1 - i;
      e_be[bc] = 1'b1;
      a_be[bc] = st;
      if (st < m_k) begin
        e_llr[bc + LLAT] = 1'b1;
        a_llr[bc + LLAT] = st;
      end
    end
    done_c = L + 2 * m_n + ALAT + LLAT + 1;
    e_done[done_c] = 1'b1;
    e_cyc[done_c]  = done_c - m_acc + 1;
    m_free_at      = done_c + 1;
    m_beta_vis     = L + 1 + m_n + ALAT;
  endtask

  task automatic model_step(input bit r, input bit s, input logic [15:0] bl, input bit vb);
    bit rdy, loading, acc_ok, ovr_n;
    if (r) begin
      for (int i = cur + 1; i < MAXC; i++) begin
        e_wr[i] = 1'b0; e_al[i] = 1'b0; e_be[i] = 1'b0; e_llr[i] = 1'b0;
        e_done[i] = 1'b0; e_elen[i] = 1'b0;
      end
      m_load = 1'b0;
      m_free_at = 0;
      m_ovr = 1'b0;
      m_beta_vis = -100;
    end else begin
      rdy = m_ready(cur);
      loading = m_load;
      acc_ok = 1'b0;
      if (s && rdy) begin
        if (bl >= 16'd40 && bl <= 16'd6144) begin
          acc_ok = 1'b1;
          m_load = 1'b1;
          m_k = int'(bl);
          m_n = int'(bl) + TAIL;
          m_beats = 0;
          m_acc = cur;
          m_beta_vis = -100;
        end else begin
          e_elen[cur + 1] = 1'b1;
        end
      end
      ovr_n = m_ovr | (vb & ~loading);
      if (acc_ok) ovr_n = 1'b0;
      if (vb && loading) begin
        e_wr[cur + 1] = 1'b1;
        a_wr[cur + 1] = m_beats;
        m_beats++;
        if (m_beats == m_n) begin
          m_load = 1'b0;
          fill_schedule(cur);
        end
      end
      m_ovr = ovr_n;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input logic [15:0] bl, input bit vb);
    @(negedge clk);
    check_outputs();
    rst = r;
    start = s;
    blklen = bl;
    valid_branch = vb;
    model_step(r, s, bl, vb);
    cur++;
  endtask

  // mode: 0 contiguous beats, 1 toggling, 2 random.
  task automatic run_block(input int len, input int mode, input bit ovr_beta,
                           input bit rst_b10, input bit noise);
    int guard;
    bit phase, stop, r, s, vb;
    logic [15:0] bl;
    guard = 0;
    while (!m_ready(cur) && guard < GUARD) begin
      cyc(1'b0, 1'b0, 16'd0, 1'b0);
      guard++;
    end
    cyc(1'b0, 1'b1, 16'(len), 1'b0);
    phase = 1'b1;
    stop = 1'b0;
    guard = 0;
    while (!stop && guard < GUARD) begin
      if (m_ready(cur)) begin
        stop = 1'b1;
      end else begin
        r = 1'b0; s = 1'b0; bl = 16'd0; vb = 1'b0;
        if (m_load) begin
          case (mode)
            0: vb = 1'b1;
            1: begin vb = phase; phase = ~phase; end
            default: vb = ($urandom_range(0, 2) != 0);
          endcase
        end
        if (ovr_beta && cur == m_beta_vis + 5) vb = 1'b1;
        if (rst_b10 && cur == m_beta_vis + 9) r = 1'b1;
        if (noise && $urandom_range(0, 7) == 0) begin
          s = 1'b1;
          bl = 16'($urandom);
        end
        cyc(r, s, bl, vb);
        guard++;
      end
    end
    chk("block_completes_within_guard", 32'(guard < GUARD), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cur);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; blklen = 16'd0; valid_branch = 1'b0;
    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    m_chk = 1'b1;
    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0, 1'b0);

    run_block(40, 0, 1'b0, 1'b0, 1'b0);
    run_block(39, 0, 1'b0, 1'b0, 1'b0);
    run_block(6145, 0, 1'b0, 1'b0, 1'b0);
    run_block(0, 0, 1'b0, 1'b0, 1'b0);
    run_block(65535, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 16'd0, 1'b0);

    run_block(40, 1, 1'b0, 1'b0, 1'b0);
    run_block(40, 0, 1'b1, 1'b0, 1'b0);
    run_block(41, 0, 1'b0, 1'b0, 1'b0);
    run_block(40, 0, 1'b0, 1'b1, 1'b0);
    run_block(40, 0, 1'b0, 1'b0, 1'b0);

    for (int b = 0; b < 8; b++) begin
      run_block($urandom_range(40, 120), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'b0, 1'b1);
      for (int g = 0; g < $urandom_range(0, 4); g++)
        cyc(1'b0, 1'b0, 16'd0, ($urandom_range(0, 3) == 0));
    end

    run_block(6144, 0, 1'b0, 1'b0, 1'b0);
    run_block(40, 2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
